bsg_arb_round_robin_weighted_ml: RTL and testbench
==================================================

Name: bsg_arb_round_robin_weighted_ml

Overview:
- Multi-level, weighted round-robin arbiter with packet locking. It succeeds the single-level round-robin arbiter for use in NoC routers and memory-request muxes.
- Requesters present a request at one of levels_p strict-priority levels.
- Within a level, the arbiter grants high-to-low with wrap-around. Each requester receives weight+1 consecutive packets before priority rotates.
- Multi-beat packets hold the grant until the last beat is accepted.

Parameters:
- width_p, (required), number of requesters; must be >= 2.
- levels_p, 2, number of priority levels; level 0 is highest.
- weight_width_p, 4, width of each per-requester weight field.
- starve_limit_p, 8, starvation-guard threshold; used only with the optional feature.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  reset; synchronous, active-high.
- reqs_i  input  levels_p*width_p  request vector; slice l is level l.
- weights_i  input  width_p*weight_width_p  quasi-static weights; requester i gets weights_i[i]+1 packets per turn.
- v_o  output  1  a grant is valid.
- grants_o  output  width_p  one-hot grant; zero when v_o=0.
- grant_level_o  output  `BSG_SAFE_CLOG2(levels_p)  level of the current grant.
- yumi_i  input  1  consumer accepts the granted beat; legal only when v_o=1.
- last_i  input  1  the accepted beat is the last beat of its packet; sampled with yumi_i.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on reset_i.
- Reset state, for every level:
  - pointer selects index width_p-1 as highest priority;
  - quota count = 0;
  - owner invalid;
  - FSM = ARB.
- Outputs are combinational from state and reqs_i. With reqs_i=0 after reset: v_o=0, grants_o=0, grant_level_o=0.
- ARB state:
  - Selected level L = lowest-numbered level with any request bit set.
  - Within L, search starts at ptr[L] and descends, wrapping from 0 to width_p-1. The first requesting index g is granted.
  - v_o = |reqs_i.
  - Grant is zero-latency: same cycle as the request.
- Yumi in ARB:
  - yumi_i with last_i=0 moves the FSM to LOCKED and records g and L. No quota update yet.
  - yumi_i with last_i=1 performs the quota update below.
- LOCKED state:
  - grants_o = onehot(g_locked) and grant_level_o = L_locked, regardless of other requests, including higher levels.
  - v_o = reqs_i[L_locked][g_locked].
  - yumi_i with last_i=1 performs the quota update and returns to ARB.
  - yumi_i with last_i=0 stays LOCKED.
- Quota update, at the end of a packet for index g at level L:
  - used = (owner[L]==g) ? cnt[L] : 0.
  - If used == weights_i[g]: ptr[L] moves to g-1 (wrapping to width_p-1), cnt[L]=0, owner invalid.
  - Otherwise: owner[L]=g, cnt[L]=used+1, ptr[L]=g, so g stays highest priority.
- Quota accounting rules:
  - A packet counts once, regardless of beat count.
  - Only the granted level's state changes; other levels' pointers are untouched.
  - If the owner drops its request mid-quota, the next requester in order wins and starts a fresh quota. The old owner's residual quota is forfeited.
- Weight changes take effect at the next packet end.
- yumi_i while v_o=0 is ignored; no state changes.
- reset_i asserted mid-packet aborts the lock and returns all state to reset values on the next edge.

Optional Feature:
- Macro: BSG_ARB_ROUND_ROBIN_WEIGHTED_ML_STARVE_GUARD_EN.
- With the macro defined:
  - A saturating counter increments on each completed packet granted at level 0 while any level>0 request is pending.
  - It clears on any completed packet at level>0.
  - When the counter equals starve_limit_p, the next ARB decision ignores level 0 and grants the lowest-numbered pending level>0, using that level's normal pointer and quota rules. The counter then clears.
- Without the macro: strict level priority; lower levels may starve. starve_limit_p is unused and the counter is not built.

Test Plan:
- Rotation, all weights 0: width_p=4, levels_p=2, weight_width_p=2. After reset, reqs level1=4'b1111; yumi_i=1, last_i=1 every cycle. Required grants: 1000, 0100, 0010, 0001, 1000; grant_level_o=1.
- Weighting: weights[3]=2, others 0, level1=1111, single-beat packets. Required grants: 1000, 1000, 1000, 0100, 0010, 0001, 1000.
- Locking:
  - Setup: level1=0101; beats accepted with last_i=0, 0, 1.
  - Stimulus: level0 bit0 raised after beat 1.
  - Required: grants_o stays 0100 at level 1 for all three beats.
  - Required next cycle: grants_o=0001, grant_level_o=0.
- Quota forfeit: weights[3]=3, level1=1111.
  - One grant to index 3, then req[3] drops. Required next grant: 0100.
  - req[3] re-raised once the pointer wraps back. Required: index 3 gets 4 fresh grants.
- Reset mid-lock: LOCKED on index 1, reset_i pulsed for 1 cycle, then level1=1111. Required: v_o=1, grants_o=1000, and the first yumi with last_i=1 is not treated as locked.
- Starve guard, macro defined, starve_limit_p=3:
  - Stimulus: level0=0001 and level1=0010 held; yumi_i=1, last_i=1 every cycle.
  - Required grant_level_o sequence: 0, 0, 0, 1 (grant 0010), 0, 0, 0, 1, ...
  - Without the macro: grant_level_o is always 0.

Source files
------------

// File: rtl/bsg_arb_round_robin_weighted_ml.sv
// bsg_arb_round_robin_weighted_ml
//   Multi-level weighted round-robin arbiter with packet locking.
//   Level 0 is the highest priority. Within a level, the search starts at
//   that level's pointer and walks downward, wrapping from 0 to width_p-1.
//   Requester i may win weights_i[i]+1 consecutive packets before the
//   pointer rotates past it. A multi-beat packet keeps its grant until the
//   beat accepted with last_i=1.
//
//   Optional build macro BSG_ARB_ROUND_ROBIN_WEIGHTED_ML_STARVE_GUARD_EN adds
//   a starvation guard: after starve_limit_p completed level-0 packets while
//   lower levels wait, one arbitration decision skips level 0.
//
// Ports
//   clk_i          clock
//   reset_i        synchronous active-high reset
//   reqs_i         request vector, slice l (width_p bits) is level l
//   weights_i      per-requester weights, weight_width_p bits each
//   v_o            grant valid
//   grants_o       one-hot grant, zero when v_o=0
//   grant_level_o  level of the current grant
//   yumi_i         consumer accepts the granted beat
//   last_i         accepted beat is the last of its packet

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

module bsg_arb_round_robin_weighted_ml #(
   parameter int width_p        = 4,
   parameter int levels_p       = 2,
   parameter int weight_width_p = 4,
   parameter int starve_limit_p = 8
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic [levels_p*width_p-1:0]          reqs_i,
   input  logic [width_p*weight_width_p-1:0]    weights_i,
   output logic                                 v_o,
   output logic [width_p-1:0]                   grants_o,
   output logic [`BSG_SAFE_CLOG2(levels_p)-1:0] grant_level_o,
   input  logic                                 yumi_i,
   input  logic                                 last_i
);

   localparam int idx_w_lp = `BSG_SAFE_CLOG2(width_p);
   localparam int lvl_w_lp = `BSG_SAFE_CLOG2(levels_p);

   typedef enum logic {ARB, LOCKED} state_e;

   state_e                                    state_r;
   logic [levels_p-1:0][idx_w_lp-1:0]         ptr_r;
   logic [levels_p-1:0][weight_width_p-1:0]   cnt_r;
   logic [levels_p-1:0]                       own_v_r;
   logic [levels_p-1:0][idx_w_lp-1:0]         own_r;
   logic [idx_w_lp-1:0]                       g_lock_r;
   logic [lvl_w_lp-1:0]                       l_lock_r;

   logic [levels_p-1:0][width_p-1:0]          reqs;
   assign reqs = reqs_i;

   logic                      sel_v;
   logic [lvl_w_lp-1:0]       sel_l;
   logic [idx_w_lp-1:0]       arb_g;
   logic [idx_w_lp-1:0]       cur_g;
   logic [lvl_w_lp-1:0]       cur_l;
   logic                      fire;
   logic                      done;
   logic [weight_width_p-1:0] used;
   logic [weight_width_p-1:0] wt;
   logic                      quota_done;

`ifdef BSG_ARB_ROUND_ROBIN_WEIGHTED_ML_STARVE_GUARD_EN
   localparam int sc_w_lp = `BSG_SAFE_CLOG2(starve_limit_p + 1);
   logic [sc_w_lp-1:0] starve_cnt_r;
   logic               lower_pend;
   logic               starve_hit;
   assign lower_pend = |reqs_i[levels_p*width_p-1:width_p];
   assign starve_hit = (starve_cnt_r == sc_w_lp'(starve_limit_p)) && lower_pend;
`endif

   // Level selection and in-level search (used only in ARB)
   always_comb begin
      sel_v = 1'b0;
      sel_l = '0;
      for (int unsigned l = 0; l < levels_p; l++) begin
         if (!sel_v && |reqs[l]) begin
            sel_v = 1'b1;
            sel_l = lvl_w_lp'(l);
         end
      end
`ifdef BSG_ARB_ROUND_ROBIN_WEIGHTED_ML_STARVE_GUARD_EN
      // Descending scan so the lowest-numbered pending level >0 wins
      if (starve_hit) begin
         for (int unsigned l = levels_p - 1; l >= 1; l--) begin
            if (|reqs[l]) sel_l = lvl_w_lp'(l);
         end
      end
`endif
      arb_g = '0;
      begin
         logic        found;
         int unsigned p;
         int unsigned idx;
         found = 1'b0;
         p     = int'(ptr_r[sel_l]);
         for (int unsigned k = 0; k < width_p; k++) begin
            idx = (p >= k) ? (p - k) : (p + width_p - k);
            if (!found && reqs[sel_l][idx]) begin
               found = 1'b1;
               arb_g = idx_w_lp'(idx);
            end
         end
      end
   end

   always_comb begin
      if (state_r == LOCKED) begin
         cur_g = g_lock_r;
         cur_l = l_lock_r;
         v_o   = reqs[l_lock_r][g_lock_r];
      end else begin
         cur_g = arb_g;
         cur_l = sel_l;
         v_o   = sel_v;
      end
      grants_o      = v_o ? (width_p'(1) << cur_g) : '0;
      grant_level_o = (state_r == LOCKED || sel_v) ? cur_l : '0;
   end

   assign fire = yumi_i & v_o;
   assign done = fire & last_i;

   // Residual quota only counts if the finishing requester is the current owner
   always_comb begin
      used       = (own_v_r[cur_l] && own_r[cur_l] == cur_g) ? cnt_r[cur_l] : '0;
      wt         = weights_i[cur_g*weight_width_p +: weight_width_p];
      quota_done = (used == wt);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r  <= ARB;
         for (int unsigned l = 0; l < levels_p; l++) begin
            ptr_r[l]   <= idx_w_lp'(width_p - 1);
            cnt_r[l]   <= '0;
            own_v_r[l] <= 1'b0;
            own_r[l]   <= '0;
         end
         g_lock_r <= '0;
         l_lock_r <= '0;
      end else if (fire) begin
         if (!last_i) begin
            state_r  <= LOCKED;
            g_lock_r <= cur_g;
            l_lock_r <= cur_l;
         end else begin
            state_r <= ARB;
            if (quota_done) begin
               ptr_r[cur_l]   <= (cur_g == '0) ? idx_w_lp'(width_p - 1) : cur_g - idx_w_lp'(1);
               cnt_r[cur_l]   <= '0;
               own_v_r[cur_l] <= 1'b0;
            end else begin
               ptr_r[cur_l]   <= cur_g;
               cnt_r[cur_l]   <= used + weight_width_p'(1);
               own_v_r[cur_l] <= 1'b1;
               own_r[cur_l]   <= cur_g;
            end
         end
      end
   end

`ifdef BSG_ARB_ROUND_ROBIN_WEIGHTED_ML_STARVE_GUARD_EN
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         starve_cnt_r <= '0;
      end else if (done) begin
         if (cur_l != '0)
            starve_cnt_r <= '0;
         else if (lower_pend && starve_cnt_r != sc_w_lp'(starve_limit_p))
            starve_cnt_r <= starve_cnt_r + sc_w_lp'(1);
      end
   end
`endif

endmodule

// File: tb/tb_bsg_arb_round_robin_weighted_ml.sv
// Scoreboard bench for bsg_arb_round_robin_weighted_ml (width 4, 2 levels,
// 2-bit weights, starve limit 3). The driver pushes the expected outputs for
// each driven cycle; a monitor pops and compares on the falling edge.

module tb_bsg_arb_round_robin_weighted_ml;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] reqs;
   logic [7:0] weights;
   logic       v;
   logic [3:0] grants;
   logic [0:0] glevel;
   logic       yumi;
   logic       last;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic       v;
      logic [3:0] g;
      logic       l;
      string      name;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   bsg_arb_round_robin_weighted_ml #(
      .width_p(4),
      .levels_p(2),
      .weight_width_p(2),
      .starve_limit_p(3)
   ) dut (
      .clk_i(clk),
      .reset_i(reset),
      .reqs_i(reqs),
      .weights_i(weights),
      .v_o(v),
      .grants_o(grants),
      .grant_level_o(glevel),
      .yumi_i(yumi),
      .last_i(last)
   );

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (v !== e.v || grants !== e.g || glevel[0] !== e.l) begin
               n_bad++;
               $display("FAIL %s: got v=%0b g=%b l=%0d, want v=%0b g=%b l=%0d",
                        e.name, v, grants, glevel, e.v, e.g, e.l);
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; reqs = '0; yumi = 1'b0; last = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic step(input logic [7:0] r, input logic y, input logic la,
                       input logic ev, input logic [3:0] eg, input logic el,
                       input string nm);
      exp_t e;
      @(posedge clk); #1;
      reqs = r; yumi = y; last = la;
      e.v = ev; e.g = eg; e.l = el; e.name = nm;
      sb.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] rot [5];
      logic [3:0] wrot [7];
      rot  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
      wrot = '{4'b1000, 4'b1000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};

      reset = 1'b1; reqs = '0; weights = '0; yumi = 1'b0; last = 1'b0;
      do_reset();
      step(8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "reset_idle");

      // Rotation, all weights 0
      for (int i = 0; i < 5; i++)
         step(8'hF0, 1'b1, 1'b1, 1'b1, rot[i], 1'b1, "rotation");

      // Weighting: requester 3 gets three packets per turn
      do_reset();
      weights = 8'b10_00_00_00;
      for (int i = 0; i < 7; i++)
         step(8'hF0, 1'b1, 1'b1, 1'b1, wrot[i], 1'b1, "weighting");

      // Locking across a higher-level request
      do_reset();
      weights = '0;
      step(8'h50, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b1, "lock_beat1");
      step(8'h51, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b1, "lock_beat2");
      step(8'h51, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, "lock_beat3");
      step(8'h51, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, "lock_release");

      // Quota forfeit
      do_reset();
      weights = 8'b11_00_00_00;
      step(8'hF0, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b1, "forfeit_first");
      step(8'h70, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, "forfeit_next");
      step(8'h70, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b1, "forfeit_wrap1");
      step(8'h70, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, "forfeit_wrap0");
      for (int i = 0; i < 4; i++)
         step(8'hF0, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b1, "forfeit_fresh");
      step(8'hF0, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, "forfeit_after");

      // Reset mid-lock
      do_reset();
      weights = '0;
      step(8'h20, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b1, "midlock_enter");
      do_reset();
      step(8'hF0, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b1, "midlock_after_reset");
      step(8'hF0, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, "midlock_not_locked");

      // yumi with no valid grant changes nothing
      step(8'h00, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, "idle_yumi");
      step(8'hF0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, "idle_yumi_no_move");

      // Starvation guard / strict priority
      do_reset();
      for (int i = 0; i < 8; i++) begin
`ifdef BSG_ARB_ROUND_ROBIN_WEIGHTED_ML_STARVE_GUARD_EN
         if (i % 4 == 3)
            step(8'h21, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b1, "starve");
         else
            step(8'h21, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b0, "starve");
`else
         step(8'h21, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b0, "strict_prio");
`endif
      end

      @(posedge clk); #1;
      yumi = 1'b0; reqs = '0;
      @(negedge clk); #1;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
